// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: angle format constants, arctangent table and FSM states.
// Angle format: 2^32 = 360 degrees, so 0x2000_0000 is 45 degrees.
package cordic_pkg;

  localparam int          ANGLE_W   = 32;
  localparam logic [31:0] ANGLE_90  = 32'h4000_0000;
  localparam logic [31:0] ANGLE_M90 = 32'hC000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // atan(2^-i) in the 32-bit angle format, i = 0..30; index 31 is unused and returns 0.
  function automatic logic [ANGLE_W-1:0] atan_lookup(input logic [4:0] idx);
    logic [ANGLE_W-1:0] val;
    case (idx)
      5'd0:    val = 32'h2000_0000;
      5'd1:    val = 32'h12E4_051E;
      5'd2:    val = 32'h09FB_385B;
      5'd3:    val = 32'h0511_11D4;
      5'd4:    val = 32'h028B_0D43;
      5'd5:    val = 32'h0145_D7E1;
      5'd6:    val = 32'h00A2_F61E;
      5'd7:    val = 32'h0051_7C55;
      5'd8:    val = 32'h0028_BE53;
      5'd9:    val = 32'h0014_5F2F;
      5'd10:   val = 32'h000A_2F98;
      5'd11:   val = 32'h0005_17CC;
      5'd12:   val = 32'h0002_8BE6;
      5'd13:   val = 32'h0001_45F3;
      5'd14:   val = 32'h0000_A2FA;
      5'd15:   val = 32'h0000_517D;
      5'd16:   val = 32'h0000_28BE;
      5'd17:   val = 32'h0000_145F;
      5'd18:   val = 32'h0000_0A30;
      5'd19:   val = 32'h0000_0518;
      5'd20:   val = 32'h0000_028C;
      5'd21:   val = 32'h0000_0146;
      5'd22:   val = 32'h0000_00A3;
      5'd23:   val = 32'h0000_0051;
      5'd24:   val = 32'h0000_0029;
      5'd25:   val = 32'h0000_0014;
      5'd26:   val = 32'h0000_000A;
      5'd27:   val = 32'h0000_0005;
      5'd28:   val = 32'h0000_0003;
      5'd29:   val = 32'h0000_0001;
      5'd30:   val = 32'h0000_0001;
      default: val = 32'h0000_0000;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational arctangent lookup: iteration index -> atan(2^-index) in angle format.
module cordic_atan_rom
  import cordic_pkg::*;
(
  input  logic [4:0]         index,
  output logic [ANGLE_W-1:0] atan
);

  // Pure table decode, no state.
  always_comb begin
    atan = atan_lookup(index);
  end

endmodule

// File: rtl/cordic_vector.sv
// Iterative vectoring-mode CORDIC: (xin, yin) -> atan2 angle and K-scaled magnitude.
// One micro-rotation per clock; result is held with full backpressure until taken.
module cordic_vector
  import cordic_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ITER  = WIDTH - 1
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [WIDTH-1:0]   xin,
  input  logic signed [WIDTH-1:0]   yin,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [ANGLE_W-1:0] angle,
  output logic [WIDTH:0]            magnitude
);

  // Two guard bits: one for negating -2^(W-1), one for the ~1.65x CORDIC gain.
  localparam int         XW   = WIDTH + 2;
  localparam logic [5:0] LAST = 6'(ITER);

  state_t                    state;
  logic [5:0]                cnt;
  logic signed [XW-1:0]      x_r;
  logic signed [XW-1:0]      y_r;
  logic signed [ANGLE_W-1:0] z_r;
  logic                      zero_r;

  logic signed [XW-1:0]      x_ext;
  logic signed [XW-1:0]      y_ext;
  logic signed [XW-1:0]      x_init;
  logic signed [XW-1:0]      y_init;
  logic signed [ANGLE_W-1:0] z_init;
  logic signed [ANGLE_W-1:0] atan_val;
  logic                      accept;
  logic                      iterate;

  assign accept  = (state == IDLE) && in_valid;
  assign iterate = (state == RUN) && (cnt != LAST);

  assign x_ext = {{2{xin[WIDTH-1]}}, xin};
  assign y_ext = {{2{yin[WIDTH-1]}}, yin};

  cordic_atan_rom u_atan_rom (
    .index (cnt[4:0]),
    .atan  (atan_val)
  );

  // Quadrant pre-rotation so the iterations only ever see x >= 0 (right half-plane).
  always_comb begin
    x_init = x_ext;
    y_init = y_ext;
    z_init = '0;
    if (xin[WIDTH-1]) begin
      if (!yin[WIDTH-1]) begin
        x_init = y_ext;
        y_init = -x_ext;
        z_init = ANGLE_90;
      end else begin
        x_init = -y_ext;
        y_init = x_ext;
        z_init = ANGLE_M90;
      end
    end
  end

  // Datapath: load the pre-rotated vector on accept, then drive y toward zero each cycle.
  always_ff @(posedge clock) begin
    if (accept) begin
      x_r    <= x_init;
      y_r    <= y_init;
      z_r    <= z_init;
      zero_r <= (xin == '0) && (yin == '0);
    end else if (iterate) begin
      if (!y_r[XW-1]) begin
        x_r <= x_r + (y_r >>> cnt);
        y_r <= y_r - (x_r >>> cnt);
        z_r <= z_r + atan_val;
      end else begin
        x_r <= x_r - (y_r >>> cnt);
        y_r <= y_r + (x_r >>> cnt);
        z_r <= z_r - atan_val;
      end
    end
  end

  // Control FSM with registered handshake flags and result registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      angle     <= '0;
      magnitude <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state    <= RUN;
            cnt      <= '0;
            in_ready <= 1'b0;
          end
        end
        RUN: begin
          if (cnt == LAST) begin
            state     <= DONE;
            cnt       <= '0;
            out_valid <= 1'b1;
            angle     <= zero_r ? '0 : z_r;
            magnitude <= zero_r ? '0 : x_r[WIDTH:0];
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_vector.sv
// Directed self-checking bench for cordic_vector (WIDTH=16, ITER=15).
module tb_cordic_vector;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] xin;
  logic signed [15:0] yin;
  logic               out_valid;
  logic               out_ready;
  logic signed [31:0] angle;
  logic [16:0]        magnitude;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cordic_vector #(.WIDTH(16), .ITER(15)) dut (
    .clock     (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .xin       (xin),
    .yin       (yin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .angle     (angle),
    .magnitude (magnitude)
  );

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ang(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    logic signed [31:0] d;
    logic               ok;
    d  = obs - exp;
    ok = (d <= 32'sd262144) && (d >= -32'sd262144);
    total++;
    assert (ok === 1'b1) else begin
      bad++;
      $error("FAIL %s observed=%08h expected=%08h (+/-2^18)", tag, obs, exp);
    end
  endtask

  task automatic chk_mag(input string tag, input logic [16:0] obs, input int exp);
    int  d;
    logic ok;
    d  = int'(obs) - exp;
    ok = (d <= 4) && (d >= -4);
    total++;
    assert (ok === 1'b1) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d (+/-4)", tag, obs, exp);
    end
  endtask

  // Present a vector and hold in_valid until the accept edge; returns #1 after that edge.
  task automatic send(input logic signed [15:0] x, input logic signed [15:0] y, output logic ok);
    xin      = x;
    yin      = y;
    in_valid = 1'b1;
    ok       = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (in_ready) ok = 1'b1;
      @(posedge clk); #1;
      if (ok) break;
    end
    in_valid = 1'b0;
  endtask

  // Wait for a result with out_ready high, take it; cyc counts edges since the call.
  task automatic recv(output logic [31:0] a, output logic [16:0] m, output int cyc, output logic ok);
    out_ready = 1'b1;
    ok        = 1'b0;
    a         = '0;
    m         = '0;
    cyc       = -1;
    for (int i = 0; i < 100; i++) begin
      if (out_valid) begin
        a   = angle;
        m   = magnitude;
        cyc = i;
        ok  = 1'b1;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
  endtask

  task automatic do_vec(input string tag, input logic signed [15:0] x, input logic signed [15:0] y,
                        input logic [31:0] exp_a, input int exp_m, input logic check_m);
    logic        ok_s, ok_r;
    logic [31:0] a;
    logic [16:0] m;
    int          cyc;
    send(x, y, ok_s);
    chk_eq({tag, "_accept"}, 64'(ok_s), 64'd1);
    recv(a, m, cyc, ok_r);
    chk_eq({tag, "_result"}, 64'(ok_r), 64'd1);
    chk_ang({tag, "_angle"}, a, exp_a);
    if (check_m) chk_mag({tag, "_mag"}, m, exp_m);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        ok_s, ok_r, stable, rdy_seen;
    logic [31:0] a0;
    logic [16:0] m0;
    int          cyc;

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    xin       = '0;
    yin       = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_eq("rst_in_ready",  64'(in_ready),  64'd1);
    chk_eq("rst_out_valid", 64'(out_valid), 64'd0);
    chk_eq("rst_angle",     64'(angle),     64'd0);
    chk_eq("rst_magnitude", 64'(magnitude), 64'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    do_vec("pos_x",    16'sd16384,  16'sd0,      32'h0000_0000, 26981, 1'b1);
    do_vec("pos_y",    16'sd0,      16'sd16384,  32'h4000_0000, 0,     1'b0);
    do_vec("q3",      -16'sd16384, -16'sd16384,  32'hA000_0000, 38157, 1'b1);
    do_vec("neg_x",   -16'sd16384,  16'sd0,      32'h8000_0000, 0,     1'b0);
    do_vec("min_min", -16'sd32768, -16'sd32768,  32'hA000_0000, 76314, 1'b1);

    // Zero vector: forced zero result, out_valid exactly 16 edges after accept.
    send(16'sd0, 16'sd0, ok_s);
    chk_eq("zero_accept", 64'(ok_s), 64'd1);
    recv(a0, m0, cyc, ok_r);
    chk_eq("zero_latency",   64'(cyc), 64'd16);
    chk_eq("zero_angle",     64'(a0),  64'd0);
    chk_eq("zero_magnitude", 64'(m0),  64'd0);

    // Backpressure: result held 20 cycles while a second vector waits.
    send(-16'sd16384, -16'sd16384, ok_s);
    chk_eq("bp_accept_a", 64'(ok_s), 64'd1);
    xin       = 16'sd16384;
    yin       = 16'sd0;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    ok_r      = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (out_valid) begin
        ok_r = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk_eq("bp_result_a", 64'(ok_r), 64'd1);
    a0       = angle;
    m0       = magnitude;
    stable   = 1'b1;
    rdy_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (!(out_valid === 1'b1 && angle === a0 && magnitude === m0)) stable = 1'b0;
      if (in_ready !== 1'b0) rdy_seen = 1'b1;
    end
    chk_eq("bp_stable",   64'(stable),   64'd1);
    chk_eq("bp_in_ready", 64'(rdy_seen), 64'd0);
    chk_ang("bp_angle_a", a0, 32'hA000_0000);
    chk_mag("bp_mag_a",   m0, 38157);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk_eq("bp_ready_after", 64'(in_ready), 64'd1);
    send(16'sd16384, 16'sd0, ok_s);
    chk_eq("bp_accept_b", 64'(ok_s), 64'd1);
    recv(a0, m0, cyc, ok_r);
    chk_eq("bp_result_b", 64'(ok_r), 64'd1);
    chk_ang("bp_angle_b", a0, 32'h0000_0000);
    chk_mag("bp_mag_b",   m0, 26981);

    // Reset during iteration 7 discards the in-flight vector.
    send(-16'sd16384, 16'sd0, ok_s);
    chk_eq("mid_accept", 64'(ok_s), 64'd1);
    repeat (7) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk_eq("mid_out_valid", 64'(out_valid), 64'd0);
    chk_eq("mid_in_ready",  64'(in_ready),  64'd1);
    chk_eq("mid_angle",     64'(angle),     64'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    do_vec("after_rst", 16'sd0, 16'sd16384, 32'h4000_0000, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
